// File: rtl/riscv_pkg.sv
// Shared types and helpers for the execute-stage iterative divider.
// Latency: n/a (types, constants and a combinational helper function only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int DIV_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // divctrl_e encodings: [3]=valid, [2]=W, [1]=REM, [0]=unsigned
  localparam logic [3:0] DIVCTRL_DIV   = 4'b1000;
  localparam logic [3:0] DIVCTRL_DIVU  = 4'b1001;
  localparam logic [3:0] DIVCTRL_REM   = 4'b1010;
  localparam logic [3:0] DIVCTRL_REMU  = 4'b1011;
  localparam logic [3:0] DIVCTRL_DIVW  = 4'b1100;
  localparam logic [3:0] DIVCTRL_DIVUW = 4'b1101;
  localparam logic [3:0] DIVCTRL_REMW  = 4'b1110;
  localparam logic [3:0] DIVCTRL_REMUW = 4'b1111;

  // Pick quotient or remainder, restore its sign, and for W-ops
  // sign-extend the low half. Negating the full width before taking the
  // low half is safe because two's complement negation is modular.
  function automatic logic [DIV_XLEN-1:0] div_fixup(
    input logic [DIV_XLEN-1:0] q,
    input logic [DIV_XLEN-1:0] r,
    input logic                neg_q,
    input logic                neg_r,
    input logic                is_rem,
    input logic                is_w
  );
    logic [DIV_XLEN-1:0] v;
    if (is_rem) v = neg_r ? (~r + 1'b1) : r;
    else        v = neg_q ? (~q + 1'b1) : q;
    if (is_w) v = {{(DIV_XLEN/2){v[DIV_XLEN/2-1]}}, v[DIV_XLEN/2-1:0]};
    return v;
  endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in next dividend bit, trial subtract.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
module riscv_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          ge;

  // Shift the partial remainder left with the dividend MSB, subtract if it fits.
  // A set top bit means the shifted value is beyond any divisor, so it always fits.
  always_comb begin
    rem_sh  = {rem[XLEN-1:0], quo[XLEN-1]};
    diff    = rem_sh - {1'b0, divisor};
    ge      = rem[XLEN] | (rem_sh >= {1'b0, divisor});
    rem_nxt = ge ? diff : rem_sh;
    quo_nxt = {quo[XLEN-2:0], ge};
  end

endmodule

// File: rtl/riscv_div_iter.sv
// Iterative radix-2 RV64M divider/remainder unit in the execute stage.
// Latency: 65 cycles (64-bit), 33 cycles (W-ops), 1 cycle (divide-by-zero / signed overflow).
// Backpressure: stall holds decode->execute while computing; hold parks the result in DONE; kill aborts.
module riscv_div_iter
  import riscv_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            i_riscv_de_clk,
  input  logic            i_riscv_de_rst,
  input  logic [3:0]      i_riscv_div_ctrl,
  input  logic [XLEN-1:0] i_riscv_div_rs1data,
  input  logic [XLEN-1:0] i_riscv_div_rs2data,
  input  logic            i_riscv_div_kill,
  input  logic            i_riscv_div_hold,
  output logic [XLEN-1:0] o_riscv_div_result,
  output logic            o_riscv_div_valid,
  output logic            o_riscv_div_stall
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic             is_rem_q, is_w_q, neg_q_q, neg_r_q;

  logic             op_vld, is_w, is_rem, is_uns;
  logic [XLEN-1:0]  a_ext, b_ext, a_abs, b_abs, min_ext;
  logic             sa, sb, div_zero, ovf, special;
  logic             ld_op, ld_spec, step_en;
  logic [XLEN:0]    rem_step;
  logic [XLEN-1:0]  quo_step;

  assign op_vld = i_riscv_div_ctrl[3];
  assign is_w   = i_riscv_div_ctrl[2];
  assign is_rem = i_riscv_div_ctrl[1];
  assign is_uns = i_riscv_div_ctrl[0];

  // Operand conditioning: W extension, sign capture, magnitudes and special-case detection.
  always_comb begin
    a_ext    = is_w ? {{HALF{~is_uns & i_riscv_div_rs1data[HALF-1]}}, i_riscv_div_rs1data[HALF-1:0]}
                    : i_riscv_div_rs1data;
    b_ext    = is_w ? {{HALF{~is_uns & i_riscv_div_rs2data[HALF-1]}}, i_riscv_div_rs2data[HALF-1:0]}
                    : i_riscv_div_rs2data;
    sa       = ~is_uns & a_ext[XLEN-1];
    sb       = ~is_uns & b_ext[XLEN-1];
    a_abs    = sa ? (~a_ext + 1'b1) : a_ext;
    b_abs    = sb ? (~b_ext + 1'b1) : b_ext;
    min_ext  = is_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = ~is_uns & (a_ext == min_ext) & (b_ext == '1);
    special  = div_zero | ovf;
  end

  riscv_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  // FSM state register.
  always_ff @(posedge i_riscv_de_clk or posedge i_riscv_de_rst) begin
    if (i_riscv_de_rst) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next state, datapath enables and handshake outputs; kill overrides every transition.
  always_comb begin
    state_nxt         = state;
    ld_op             = 1'b0;
    ld_spec           = 1'b0;
    step_en           = 1'b0;
    o_riscv_div_valid = (state == DONE) & ~i_riscv_div_kill;
    o_riscv_div_stall = op_vld & (state != DONE) & ~i_riscv_div_kill;
    if (i_riscv_div_kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_vld) begin
            if (special) begin
              state_nxt = DONE;
              ld_spec   = 1'b1;
            end else begin
              state_nxt = BUSY;
              ld_op     = 1'b1;
            end
          end
        end
        BUSY: begin
          step_en = 1'b1;
          if (cnt == '0) state_nxt = DONE;
        end
        DONE: begin
          if (!i_riscv_div_hold) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture on IDLE exit, then one restoring step per BUSY cycle.
  // W magnitudes are parked in the upper half so the step always consumes the MSB.
  always_ff @(posedge i_riscv_de_clk or posedge i_riscv_de_rst) begin
    if (i_riscv_de_rst) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      is_w_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else if (ld_op) begin
      cnt      <= is_w ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
      rem_q    <= '0;
      quo_q    <= is_w ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
      dvs_q    <= b_abs;
      is_rem_q <= is_rem;
      is_w_q   <= is_w;
      neg_q_q  <= sa ^ sb;
      neg_r_q  <= sa;
    end else if (ld_spec) begin
      cnt      <= '0;
      rem_q    <= div_zero ? {1'b0, i_riscv_div_rs1data} : '0;
      quo_q    <= div_zero ? '1 : min_ext;
      dvs_q    <= '0;
      is_rem_q <= is_rem;
      is_w_q   <= is_w;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else if (step_en) begin
      cnt      <= cnt - CNT_W'(1);
      rem_q    <= rem_step;
      quo_q    <= quo_step;
    end
  end

  // Result is driven only in DONE so the mux sees zero otherwise.
  always_comb begin
    o_riscv_div_result = '0;
    if (state == DONE)
      o_riscv_div_result = div_fixup(quo_q, rem_q[XLEN-1:0], neg_q_q, neg_r_q, is_rem_q, is_w_q);
  end

endmodule

// File: tb/tb_riscv_div_iter.sv
// Self-checking bench for riscv_div_iter: vector table plus multi-cycle corner sequences.
// Latency: checks exact cycle of valid against the expected latency per op.
// Backpressure: exercises hold, kill, reset and back-to-back issue.
module tb_riscv_div_iter;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ctrl;
  logic [63:0] rs1, rs2;
  logic        kill, hold;
  logic [63:0] result;
  logic        valid, stall;

  int          checks = 0;
  int          failures = 0;
  longint      cycle_cnt = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];

  riscv_div_iter dut (
    .i_riscv_de_clk      (clk),
    .i_riscv_de_rst      (rst),
    .i_riscv_div_ctrl    (ctrl),
    .i_riscv_div_rs1data (rs1),
    .i_riscv_div_rs2data (rs2),
    .i_riscv_div_kill    (kill),
    .i_riscv_div_hold    (hold),
    .o_riscv_div_result  (result),
    .o_riscv_div_valid   (valid),
    .o_riscv_div_stall   (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Issue one op at the next edge, wait for valid, compare against the scoreboard.
  // Returns at the negedge of the last DONE cycle with ctrl still asserted.
  task automatic apply_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input int el, input bit scramble,
                          input int hold_n, output longint vcyc);
    exp_t e;
    int   cyc;
    bit   stall_bad;
    bit   got;
    @(posedge clk); #1;
    ctrl = c; rs1 = a; rs2 = b;
    e.res = er; e.lat = el;
    sb.push_back(e);
    cyc = 0; stall_bad = 0; got = 0;
    while (!got && cyc <= 200) begin
      @(negedge clk);
      if (valid) got = 1;
      else begin
        if (stall !== 1'b1) stall_bad = 1;
        cyc++;
        if (scramble && cyc >= 2) begin
          rs1 = {$urandom, $urandom};
          rs2 = {$urandom, $urandom};
        end
      end
    end
    e = sb.pop_front();
    vcyc = cycle_cnt;
    if (!got) begin
      chk("timeout_valid", 64'd0, 64'd1);
      return;
    end
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("result", result, e.res);
    chk("stall_before_done", 64'(stall_bad), 64'd0);
    chk("stall_in_done", 64'(stall), 64'd0);
    if (hold_n > 0) begin
      hold = 1'b1;
      for (int i = 1; i <= hold_n; i++) begin
        @(negedge clk);
        chk("hold_valid", 64'(valid), 64'd1);
        chk("hold_result", result, e.res);
        if (i == hold_n) hold = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    bit bad;
    @(posedge clk); #1;
    ctrl = 4'b0000;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid !== 1'b0) bad = 1;
    end
    chk("idle_no_valid", 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    longint v1, v2;
    bit     bad;

    vecs[0]  = '{DIVCTRL_DIV,   64'd100, 64'd7, 64'd14, 65};
    vecs[1]  = '{DIVCTRL_REM,   64'd100, 64'd7, 64'd2, 65};
    vecs[2]  = '{DIVCTRL_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{DIVCTRL_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{DIVCTRL_REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 65};
    vecs[5]  = '{DIVCTRL_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{DIVCTRL_REM,   64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{DIVCTRL_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{DIVCTRL_DIVW,  64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[9]  = '{DIVCTRL_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};
    vecs[10] = '{DIVCTRL_REMW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[11] = '{DIVCTRL_REMUW, 64'h0000_0000_FFFF_FFFF, 64'd10, 64'd5, 33};
    vecs[12] = '{DIVCTRL_REMW,  64'h0000_0001_8000_0000, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[13] = '{DIVCTRL_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[14] = '{DIVCTRL_REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
    vecs[15] = '{DIVCTRL_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
    vecs[16] = '{DIVCTRL_DIVW,  64'h0000_0000_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33};
    vecs[17] = '{DIVCTRL_DIVUW, 64'hDEAD_BEEF_0000_0007, 64'h1234_0000_0000_0003, 64'd2, 33};
    vecs[18] = '{DIVCTRL_DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[19] = '{DIVCTRL_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};

    rst = 1'b1; ctrl = 4'b0000; rs1 = '0; rs2 = '0; kill = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_stall_idle", 64'(stall), 64'd0);
    ctrl = DIVCTRL_DIV; #1;
    chk("rst_stall_follows_ctrl", 64'(stall), 64'd1);
    ctrl = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: odd entries also scramble operands while BUSY.
    for (int i = 0; i < 20; i++) begin
      apply_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, bit'(i % 2), 0, v1);
      idle(3);
    end

    // Hold for three cycles in DONE.
    apply_op(DIVCTRL_DIV, 64'd100, 64'd7, 64'd14, 65, 1'b0, 3, v1);
    idle(4);

    // Back-to-back DIV then REM with no bubble.
    apply_op(DIVCTRL_DIV, 64'd100, 64'd7, 64'd14, 65, 1'b0, 0, v1);
    apply_op(DIVCTRL_REM, 64'd100, 64'd7, 64'd2, 65, 1'b0, 0, v2);
    chk("b2b_gap", 64'(v2 - v1), 64'd66);
    idle(3);

    // Kill at cycle 20 of a DIV.
    @(posedge clk); #1;
    ctrl = DIVCTRL_DIV; rs1 = 64'd100; rs2 = 64'd7;
    repeat (20) @(posedge clk);
    #1;
    kill = 1'b1;
    @(negedge clk);
    chk("kill_stall", 64'(stall), 64'd0);
    chk("kill_valid", 64'(valid), 64'd0);
    @(posedge clk); #1;
    kill = 1'b0; ctrl = 4'b0000;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid !== 1'b0) bad = 1;
    end
    chk("kill_no_valid", 64'(bad), 64'd0);
    apply_op(DIVCTRL_DIV, 64'd100, 64'd7, 64'd14, 65, 1'b0, 0, v1);
    idle(2);

    // Reset at cycle 30 of a DIV.
    @(posedge clk); #1;
    ctrl = DIVCTRL_DIV; rs1 = 64'd100; rs2 = 64'd7;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    chk("midbusy_rst_valid", 64'(valid), 64'd0);
    chk("midbusy_rst_result", result, 64'd0);
    chk("midbusy_rst_stall", 64'(stall), 64'd1);
    ctrl = 4'b0000; #1;
    chk("midbusy_rst_stall_noop", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_op(DIVCTRL_REM, 64'd100, 64'd7, 64'd2, 65, 1'b0, 0, v1);
    idle(2);

    // Reset while a result is parked in DONE under hold.
    @(posedge clk); #1;
    ctrl = DIVCTRL_DIVU; rs1 = 64'd5; rs2 = 64'd0; hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("done_hold_valid", 64'(valid), 64'd1);
    chk("done_hold_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b1; #1;
    chk("done_rst_valid", 64'(valid), 64'd0);
    chk("done_rst_result", result, 64'd0);
    ctrl = 4'b0000; hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
